// File: rtl/rr_grant_ctrl_if.sv
// rr_grant_ctrl_if
// Bundles the requester-side handshake and the decoder-side grant outputs
// of the round-robin arbiter into one interface.
//   arb_en      : 1 = new grants may be issued
//   req[7:0]    : request vector, bit i = requester i
//   done        : release pulse from the current owner
//   grant_idx   : index of the current owner (decoder select input)
//   grant_valid : grant active (decoder enable)
//   grant[7:0]  : one-hot grant, zero when grant_valid is low
//   busy        : arbiter is in an ownership or dead-cycle period
//   timeout     : one-cycle pulse on a forced release
// master drives the requests (requester bank / testbench),
// slave is the arbiter itself.
interface rr_grant_ctrl_if;
    logic       arb_en;
    logic [7:0] req;
    logic       done;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        output arb_en, req, done,
        input  grant_idx, grant_valid, grant, busy, timeout
    );

    modport slave (
        input  arb_en, req, done,
        output grant_idx, grant_valid, grant, busy, timeout
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl
// Eight-way round-robin arbiter feeding a 3-to-8 one-hot select decoder.
// Each ownership period runs grant -> hold until release -> one dead cycle,
// so the decoder enable is always low for at least one cycle between owners.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : rr_grant_ctrl_if.slave (arb_en, req, done in;
//          grant_idx, grant_valid, grant, busy, timeout out)
// Parameters:
//   TIMEOUT : maximum hold cycles before a forced release (2..255)
//   CNT_W   : hold counter width, 2**CNT_W > TIMEOUT
// Optional feature:
//   RR_GRANT_TIMEOUT_EN - when defined, a grant held for TIMEOUT cycles
//   without release is forcibly released and timeout pulses during the
//   dead cycle. When undefined, the hold counter is not built, timeout is
//   tied low and TIMEOUT is ignored.
module rr_grant_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_grant_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // last is the round-robin pointer (resets to 7 so requester 0 has
    // top priority first); owner drives grant_idx and resets to 0. They
    // carry the same value after the first grant but reset differently.
    logic [2:0] last;
    logic [2:0] owner;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       grant_start;
    logic       release_now;
    logic       force_rel;

    // Rotating priority search: last+1 first, last itself last.
    always_comb begin
        found  = 1'b0;
        winner = last;
        cand   = last;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant_start = (state == IDLE) && bus.arb_en && found;

    // A withdrawn request releases the grant just like done does.
    assign release_now = bus.done || !bus.req[owner];

`ifdef RR_GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             to_flag;

    assign force_rel = (state == BUSY) && (cnt == CNT_W'(TIMEOUT - 1));

    // Hold counter: cleared on a new grant, counts BUSY cycles, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant_start) begin
            cnt <= '0;
        end else if (state == BUSY && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The flag is only raised when the timeout alone ends the grant; it
    // lasts exactly the dead cycle that follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_flag <= 1'b0;
        end else begin
            to_flag <= force_rel && !release_now;
        end
    end
`else
    logic unused_cfg;

    assign force_rel  = 1'b0;
    assign unused_cfg = (TIMEOUT != 0) ^ (CNT_W != 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. done outside BUSY falls through unused.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant_start) state_nxt = BUSY;
            BUSY: if (release_now || force_rel) state_nxt = GAP;
            GAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner capture: owner and round-robin pointer load together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last  <= 3'd7;
            owner <= 3'd0;
        end else if (grant_start) begin
            last  <= winner;
            owner <= winner;
        end
    end

    // Outputs decode only from flops, so no input reaches an output
    // combinationally and reset clears them without a clock edge.
    always_comb begin
        bus.grant_idx   = owner;
        bus.grant_valid = (state == BUSY);
        bus.busy        = (state != IDLE);
        bus.grant       = 8'h00;
        if (state == BUSY) begin
            bus.grant[owner] = 1'b1;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        bus.timeout = to_flag;
`else
        bus.timeout = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl
// Self-checking bench for rr_grant_ctrl: a table of directed vectors,
// hand-written multi-cycle sequences (round-robin sweep, asynchronous
// reset, long hold / timeout) and a randomized run checked against a
// cycle-level reference model of the arbitration rules.
module tb_rr_grant_ctrl;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit ToEn       = 1'b1;
    localparam int TbTimeout  = 4;
`else
    localparam bit ToEn       = 1'b0;
    localparam int TbTimeout  = 16;
`endif

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [2:0] idx;
        logic       valid;
        logic [7:0] grant;
        logic       busy;
        logic       to;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    // Reference model state.
    int   mLast;
    int   mIdx;
    bit   mOwning;
    bit   mGap;
    bit   mTo;
    int   mHeld;

    rr_grant_ctrl_if bus ();

    rr_grant_ctrl #(
        .TIMEOUT (TbTimeout),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic [7:0] r, input logic d,
                                input logic [2:0] idx, input logic v, input logic [7:0] g,
                                input logic b, input logic t);
        vec_t x;
        x.en = en; x.req = r; x.done = d;
        x.idx = idx; x.valid = v; x.grant = g; x.busy = b; x.to = t;
        return x;
    endfunction

    // Drive inputs, let one rising edge pass, settle 1 ns after it.
    task automatic applyStimulus(input logic en, input logic [7:0] r, input logic d);
        bus.arb_en = en;
        bus.req    = r;
        bus.done   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eIdx, input logic eV,
                               input logic [7:0] eG, input logic eB, input logic eT);
        logic [13:0] act;
        logic [13:0] exp;
        act = {bus.grant_idx, bus.grant_valid, bus.grant, bus.busy, bus.timeout};
        exp = {eIdx, eV, eG, eB, eT};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got idx=%0d valid=%0b grant=%02h busy=%0b timeout=%0b, expected idx=%0d valid=%0b grant=%02h busy=%0b timeout=%0b",
                     name, bus.grant_idx, bus.grant_valid, bus.grant, bus.busy, bus.timeout,
                     eIdx, eV, eG, eB, eT);
        end
    endtask

    task automatic modelReset();
        mLast   = 7;
        mIdx    = 0;
        mOwning = 0;
        mGap    = 0;
        mTo     = 0;
        mHeld   = 0;
    endtask

    // One clock edge of the arbitration rules, given the sampled inputs.
    task automatic modelStep(input logic en, input logic [7:0] r, input logic d);
        bit rel;
        bit frc;
        if (mOwning) begin
            rel = d || !r[mIdx];
            frc = ToEn && (mHeld == TbTimeout - 1);
            if (rel || frc) begin
                mOwning = 0;
                mGap    = 1;
                mTo     = frc && !rel;
            end else begin
                mHeld++;
            end
        end else if (mGap) begin
            mGap = 0;
            mTo  = 0;
        end else if (en && r != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
                if (!mOwning && r[(mLast + k) % 8]) begin
                    mOwning = 1;
                    mIdx    = (mLast + k) % 8;
                end
            end
            mLast = mIdx;
            mHeld = 0;
        end
    endtask

    task automatic modelCheck(input string name);
        logic [7:0] g;
        g = 8'h00;
        if (mOwning) g[mIdx] = 1'b1;
        checkOutput(name, 3'(mIdx), mOwning, g, mOwning || mGap, mTo);
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        bus.arb_en = 1'b0;
        bus.req    = 8'h00;
        bus.done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [7:0] r;
        logic       en;
        logic       d;

        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        modelReset();

        // Directed table: single requester, wrap-around, arb_en gating,
        // request withdrawal.
        vecs.push_back(mk(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h02, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h02, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h82, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b1, 3'd4, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h08, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0));

        applyReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].req, vecs[i].done);
            checkOutput($sformatf("vec%0d", i), vecs[i].idx, vecs[i].valid,
                        vecs[i].grant, vecs[i].busy, vecs[i].to);
        end

        // Round-robin sweep with all requesters active: 0,1,...,7,0.
        applyReset();
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0);
            checkOutput($sformatf("rr_grant%0d", n), 3'(n % 8), 1'b1, 8'(1 << (n % 8)), 1'b1, 1'b0);
            applyStimulus(1'b1, 8'hFF, 1'b1);
            checkOutput($sformatf("rr_gap%0d", n), 3'(n % 8), 1'b0, 8'h00, 1'b1, 1'b0);
            applyStimulus(1'b1, 8'hFF, 1'b0);
            checkOutput($sformatf("rr_idle%0d", n), 3'(n % 8), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of an ownership period.
        applyReset();
        applyStimulus(1'b1, 8'h40, 1'b0);
        checkOutput("pre_rst_grant", 3'd6, 1'b1, 8'h40, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("post_rst_ptr", 3'd0, 1'b1, 8'h01, 1'b1, 1'b0);

        // Long hold with no release.
        applyReset();
        applyStimulus(1'b1, 8'h04, 1'b0);
        checkOutput("hold_grant", 3'd2, 1'b1, 8'h04, 1'b1, 1'b0);
`ifdef RR_GRANT_TIMEOUT_EN
        for (int c = 1; c < TbTimeout; c++) begin
            applyStimulus(1'b1, 8'h04, 1'b0);
            checkOutput($sformatf("to_hold%0d", c), 3'd2, 1'b1, 8'h04, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 8'h04, 1'b0);
        checkOutput("to_pulse", 3'd2, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h04, 1'b0);
        checkOutput("to_idle", 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h04, 1'b0);
        checkOutput("to_regrant", 3'd2, 1'b1, 8'h04, 1'b1, 1'b0);
`else
        for (int c = 1; c < 40; c++) begin
            applyStimulus(1'b1, 8'h04, 1'b0);
            checkOutput($sformatf("hold%0d", c), 3'd2, 1'b1, 8'h04, 1'b1, 1'b0);
        end
`endif

        // Randomized run against the reference model.
        applyReset();
        r = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) >= 70) r = 8'($urandom);
            en = ($urandom_range(0, 99) < 80);
            d  = ($urandom_range(0, 99) < 20);
            applyStimulus(en, r, d);
            modelStep(en, r, d);
            modelCheck($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
